data_memory_responder: RTL

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 104 ++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - single-cycle CPU data memory: RAM, LED register, TX byte FIFO, status and cycle counter
module data_memory_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] data_memory_addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  // Peripheral registers decoded on word address (byte address >> 2)
  localparam logic [29:0] LED_WADDR    = 30'h2000_0000;
  localparam logic [29:0] TX_WADDR     = 30'h2000_0001;
  localparam logic [29:0] STATUS_WADDR = 30'h2000_0002;
  localparam logic [29:0] CNT_WADDR    = 30'h2000_0003;

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   cycle_count;

  logic [29:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          in_ram, sel_led, sel_tx, sel_status, sel_cnt;
  logic          full, empty, pop, push_req, push_ok;
  logic          addr_unused;

  assign word_addr   = data_memory_addr[31:2];
  assign ram_idx     = data_memory_addr[AW+1:2];
  assign addr_unused = ^data_memory_addr[1:0];
  assign in_ram      = (data_memory_addr[31:AW+2] == '0);
  assign sel_led     = (word_addr == LED_WADDR);
  assign sel_tx      = (word_addr == TX_WADDR);
  assign sel_status  = (word_addr == STATUS_WADDR);
  assign sel_cnt     = (word_addr == CNT_WADDR);

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign tx_valid = !empty;
  assign tx_data  = fifo[head];
  assign pop      = tx_valid && tx_ready;
  assign push_req = mem_write && sel_tx;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands
  assign push_ok  = push_req && (!full || pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    read_data = '0;
    if (in_ram)          read_data = ram[ram_idx];
    else if (sel_led)    read_data = {24'b0, led};
    else if (sel_status) read_data = {29'b0, overflow, full, empty};
    else if (sel_cnt)    read_data = cycle_count;
  end

  // Storage arrays are not reset, but reset still blocks writes into them
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (mem_write && in_ram) ram[ram_idx] <= write_data;
      if (push_ok)             fifo[tail]   <= write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led         <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (mem_write && sel_led) led <= write_data[7:0];
      if (push_ok) tail <= ptr_inc(tail);
      if (pop)     head <= ptr_inc(head);
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_write && sel_status)  overflow <= 1'b0;
      else if (push_req && !push_ok) overflow <= 1'b1;
      cycle_count <= (mem_write && sel_cnt) ? 32'd0 : cycle_count + 32'd1;
    end
  end

endmodule
